// File: rtl/usb_rst_sequencer_if.sv
// Avalon-MM register bus between the Nios II data master and the USB reset
// sequencer.
//   address    : register select (2 bits)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : 32-bit write data
//   readdata   : 32-bit read data, combinational from the slave
interface usb_rst_sequencer_if;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 32;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/usb_rst_sequencer.sv
// USB host controller reset sequencer.
// Drives the chip's RES# line with a timed low pulse followed by a settle
// window, then flags READY and raises a completion interrupt. One sequence
// runs automatically out of system reset; software can re-run or abort it.
//
// Ports:
//   clk       : system clock, rising edge
//   reset     : asynchronous active-high reset
//   bus       : Avalon-MM slave (CTRL, STATUS, PULSE_LEN, WAIT_LEN)
//   usb_rst_n : to USB chip RES#, 0 holds the chip in reset (registered)
//   irq       : level completion interrupt, irq_pend & IEN
//
// Register map:
//   0 CTRL      : [0] START (pulse), [1] ABORT (pulse), [2] IEN
//   1 STATUS    : [0] BUSY, [1] READY, [2] IRQ_PEND (W1C), [3] ~usb_rst_n
//   2 PULSE_LEN : [CNT_W-1:0], writable in IDLE only
//   3 WAIT_LEN  : [CNT_W-1:0], writable in IDLE only
module usb_rst_sequencer #(
    parameter int unsigned CNT_W     = 24,
    parameter int unsigned DEF_PULSE = 500,
    parameter int unsigned DEF_WAIT  = 5000
) (
    input  logic                 clk,
    input  logic                 reset,
    usb_rst_sequencer_if.slave   bus,
    output logic                 usb_rst_n,
    output logic                 irq
);

    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_PULSE  = 2'd2;
    localparam logic [1:0] REG_WAIT   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   pulse_len_q, pulse_len_d;
    logic [CNT_W-1:0]   wait_len_q, wait_len_d;
    logic               ien_q, ien_d;
    logic               ready_q, ready_d;
    logic               irq_pend_q, irq_pend_d;
    logic               usb_rst_n_d;

    logic               wr;
    logic               ctrl_wr;
    logic               start_req;
    logic               abort_req;
    logic               w1c_req;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   pulse_last;
    logic [CNT_W-1:0]   wait_last;
    logic [DATA_W-1:0]  rdata;
    logic               unused_wdata;

    // Bus decode
    assign wr        = bus.chipselect & ~bus.write_n;
    assign ctrl_wr   = wr && (bus.address == REG_CTRL);
    assign start_req = ctrl_wr & bus.writedata[0];
    assign abort_req = ctrl_wr & bus.writedata[1];
    assign w1c_req   = wr && (bus.address == REG_STATUS) && bus.writedata[2];
    assign busy      = (state_q != ST_IDLE);

    // A zero pulse length still produces a one-cycle pulse
    assign pulse_last = (pulse_len_q == '0) ? '0 : pulse_len_q - CNT_W'(1);
    // Only used in WAIT, which is never entered with WAIT_LEN == 0
    assign wait_last  = wait_len_q - CNT_W'(1);

    // Upper write-data bits are don't-care for every register
    assign unused_wdata = ^bus.writedata;

    // Next-state, counter and register updates
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        done        = 1'b0;
        ready_d     = ready_q;
        irq_pend_d  = irq_pend_q;
        ien_d       = ien_q;
        pulse_len_d = pulse_len_q;
        wait_len_d  = wait_len_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start_req) begin
                    state_d = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (cnt_q == pulse_last) begin
                    cnt_d = '0;
                    if (wait_len_q != '0) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_IDLE;
                        done    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (cnt_q == wait_last) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    done    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // ABORT overrides both START and a completion on the same edge
        if (abort_req) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            done    = 1'b0;
        end

        if (!busy && start_req && !abort_req) begin
            ready_d = 1'b0;
        end
        if (done) begin
            ready_d = 1'b1;
        end

        // Completion beats a coincident W1C
        if (done) begin
            irq_pend_d = 1'b1;
        end else if (w1c_req) begin
            irq_pend_d = 1'b0;
        end

        if (ctrl_wr) begin
            ien_d = bus.writedata[2];
        end

        if (wr && !busy && (bus.address == REG_PULSE)) begin
            pulse_len_d = bus.writedata[CNT_W-1:0];
        end
        if (wr && !busy && (bus.address == REG_WAIT)) begin
            wait_len_d = bus.writedata[CNT_W-1:0];
        end
    end

    // RES# is low exactly while the FSM sits in ASSERT
    assign usb_rst_n_d = (state_d != ST_ASSERT);

    // State register; reset lands in ASSERT so the power-on pulse begins at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_ASSERT;
            cnt_q       <= '0;
            usb_rst_n   <= 1'b0;
            pulse_len_q <= CNT_W'(DEF_PULSE);
            wait_len_q  <= CNT_W'(DEF_WAIT);
            ien_q       <= 1'b0;
            ready_q     <= 1'b0;
            irq_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            usb_rst_n   <= usb_rst_n_d;
            pulse_len_q <= pulse_len_d;
            wait_len_q  <= wait_len_d;
            ien_q       <= ien_d;
            ready_q     <= ready_d;
            irq_pend_q  <= irq_pend_d;
        end
    end

    // Read mux, independent of chipselect
    always_comb begin
        rdata = '0;
        case (bus.address)
            REG_CTRL:   rdata = {29'd0, ien_q, 2'b00};
            REG_STATUS: rdata = {28'd0, ~usb_rst_n, irq_pend_q, ready_q, busy};
            REG_PULSE:  rdata = DATA_W'(pulse_len_q);
            REG_WAIT:   rdata = DATA_W'(wait_len_q);
            default:    rdata = '0;
        endcase
    end

    assign bus.readdata = rdata;

    assign irq = irq_pend_q & ien_q;

endmodule

// File: doc/usb_rst_sequencer.md
Name: usb_rst_sequencer

Overview:
Avalon-MM slave that sequences the USB host controller's hardware reset line.
- Generates a timed active-low reset pulse, then a post-reset settle window, then flags the chip ready.
- Runs one sequence automatically after system reset; software can re-run or abort it.
- Sits in the SoC between the Nios II data master and the USB controller's RES# pin, replacing a bare PIO reset bit.

Parameters:
CNT_W, 24, width of the cycle counter and the length registers
DEF_PULSE, 500, reset value of PULSE_LEN in clk cycles (10 us at 50 MHz)
DEF_WAIT, 5000, reset value of WAIT_LEN in clk cycles (100 us at 50 MHz)

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
address  in  2  register select
chipselect  in  1  slave select
write_n  in  1  active-low write strobe; write = chipselect & ~write_n
writedata  in  32  write data
readdata  out  32  combinational read data, zero-extended; does not depend on chipselect
usb_rst_n  out  1  to USB chip RES#; 0 = chip held in reset
irq  out  1  completion interrupt, level, = irq_pend & IEN

Behaviour:
Registers:
- 0 CTRL: bit0 START (write-only pulse, reads 0); bit1 ABORT (write-only pulse, reads 0); bit2 IEN (R/W).
- 1 STATUS: bit0 BUSY, bit1 READY, bit2 IRQ_PEND (W1C), bit3 = ~usb_rst_n.
- 2 PULSE_LEN [CNT_W-1:0]
- 3 WAIT_LEN [CNT_W-1:0]
- Unused bits read 0.

Reset (async):
- state=ASSERT, cnt=0, usb_rst_n=0.
- PULSE_LEN=DEF_PULSE, WAIT_LEN=DEF_WAIT.
- IEN=0, READY=0, irq_pend=0, irq=0.
- An auto power-on sequence starts on the first edge after reset release.

FSM states (BUSY = state != IDLE):
- IDLE: usb_rst_n=1, cnt held at 0.
- ASSERT: usb_rst_n=0, cnt increments each cycle. When cnt == max(PULSE_LEN,1)-1: cnt<=0; next state = WAIT if WAIT_LEN != 0, else IDLE with completion.
- WAIT: usb_rst_n=1, cnt increments. When cnt == WAIT_LEN-1: state<=IDLE, cnt<=0, completion.

Completion (registered, same edge as the IDLE transition):
- READY<=1, irq_pend<=1.
- Consequences: the pulse is exactly max(PULSE_LEN,1) cycles low; the settle window is exactly WAIT_LEN cycles; READY rises on the cycle after the last WAIT cycle.

START:
- Accepted only in IDLE: state<=ASSERT, cnt<=0, READY<=0.
- usb_rst_n falls on the next edge.
- Ignored while BUSY.

ABORT:
- Any state: state<=IDLE, cnt<=0, usb_rst_n<=1.
- READY unchanged, no completion event.
- ABORT has priority over START in the same write.

Register writes:
- PULSE_LEN/WAIT_LEN writes are ignored while BUSY; they take effect in IDLE only.
- IEN is writable in any state.
- STATUS write: bit2=1 clears irq_pend.
- If completion and W1C coincide, set wins (irq_pend=1).

Timing: every write takes effect on the edge where it is sampled; there are no wait states.

Reset mid-operation: returns immediately to the reset values and restarts the auto sequence.

Test Plan:
1. Power-on, DEF_PULSE=4, DEF_WAIT=3: release reset -> usb_rst_n=0 for exactly 4 cycles, then 1; READY=1 and BUSY=0 on the cycle after 3 WAIT cycles; irq stays 0 because IEN=0, while IRQ_PEND=1.
2. In IDLE, write PULSE_LEN=2, WAIT_LEN=0, CTRL=0x5 (START+IEN) -> usb_rst_n low 2 cycles, no WAIT, READY=1 and irq=1 right after; write STATUS=0x4 -> irq=0.
3. PULSE_LEN=0, START -> pulse is exactly 1 cycle.
4. During WAIT: write PULSE_LEN=9 -> readback unchanged. Write START -> ignored, sequence length unchanged. Write CTRL=0x3 -> IDLE next edge, usb_rst_n=1, READY stays 0, IRQ_PEND stays 0.
5. W1C on STATUS written on the same edge as completion -> IRQ_PEND reads 1 afterward.
6. Assert reset during the WAIT of a software sequence -> usb_rst_n=0 immediately; registers return to defaults; auto sequence repeats with DEF_PULSE/DEF_WAIT.
